dac_spi_streamer: RTL and testbench

DAC_SPI_STREAMER -- requirements
Module: dac_spi_streamer

---
 rtl/dac_spi_streamer.sv | 206 ++++++++++++++++++++
 tb/tb_dac_spi_streamer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_streamer.sv
// Sample-rate ticker feeding a 16-bit SPI mode-0 frame ({CTRL_BITS, sample, 2'b00}) to a DAC.
// Optional macro DAC_SPI_LDAC_EN adds an LDAC state with an ldac_n strobe; otherwise ldac_n is tied low.
module dac_spi_streamer #(
   parameter int unsigned CLK_DIV    = 2,
   parameter int unsigned SAMPLE_DIV = 100,
   parameter logic [3:0]  CTRL_BITS  = 4'b0011
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [9:0] sample_in,
   output logic       sclk,
   output logic       cs_n,
   output logic       mosi,
   output logic       ldac_n,
   output logic       busy,
   output logic       overrun,
   output logic [7:0] overrun_cnt
);

`ifdef DAC_SPI_LDAC_EN
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_LDAC = 2'd2, ST_GAP = 2'd3} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_GAP = 2'd3} state_t;
`endif

   localparam logic [15:0] TICK_MAX = 16'(SAMPLE_DIV - 1);
   localparam logic [7:0]  DIV_MAX  = 8'(CLK_DIV - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [15:0] r_tick_cnt;
   logic        w_tick;
   logic        w_drop;
   logic [7:0]  r_div;
   logic [7:0]  w_div_nxt;
   logic [3:0]  r_bit;
   logic [3:0]  w_bit_nxt;
   logic [15:0] r_shift;
   logic [15:0] w_shift_nxt;
   logic        r_sclk;
   logic        w_sclk_nxt;
   logic        r_cs_n;
   logic        w_cs_n_nxt;
   logic        r_busy;
   logic        r_overrun;
   logic [7:0]  r_overrun_cnt;
`ifdef DAC_SPI_LDAC_EN
   logic        r_ldac_n;
   logic        w_ldac_n_nxt;
`endif

   assign w_tick = enable && (r_tick_cnt == TICK_MAX);
   assign w_drop = w_tick && (r_state != ST_IDLE);

   // Sample-period counter, parked at zero while disabled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tick_cnt <= 16'd0;
      end else if (!enable || (r_tick_cnt == TICK_MAX)) begin
         r_tick_cnt <= 16'd0;
      end else begin
         r_tick_cnt <= r_tick_cnt + 16'd1;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and next-output logic; shifting happens only on the sclk falling toggle.
   always_comb begin
      w_state_nxt = r_state;
      w_div_nxt   = r_div;
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_sclk_nxt  = r_sclk;
      w_cs_n_nxt  = r_cs_n;
`ifdef DAC_SPI_LDAC_EN
      w_ldac_n_nxt = r_ldac_n;
`endif
      case (r_state)
         ST_IDLE: begin
            w_div_nxt  = 8'd0;
            w_bit_nxt  = 4'd0;
            w_sclk_nxt = 1'b0;
            if (w_tick) begin
               w_state_nxt = ST_SHIFT;
               w_shift_nxt = {CTRL_BITS, sample_in, 2'b00};
               w_cs_n_nxt  = 1'b0;
            end else begin
               w_shift_nxt = 16'd0;
               w_cs_n_nxt  = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (r_div == DIV_MAX) begin
               w_div_nxt  = 8'd0;
               w_sclk_nxt = ~r_sclk;
               if (r_sclk && (r_bit == 4'd15)) begin
                  w_cs_n_nxt  = 1'b1;
                  w_shift_nxt = 16'd0;
                  w_bit_nxt   = 4'd0;
`ifdef DAC_SPI_LDAC_EN
                  w_state_nxt  = ST_LDAC;
                  w_ldac_n_nxt = 1'b0;
`else
                  w_state_nxt = ST_GAP;
`endif
               end else if (r_sclk) begin
                  w_bit_nxt   = r_bit + 4'd1;
                  w_shift_nxt = {r_shift[14:0], 1'b0};
               end else begin
                  w_bit_nxt = r_bit;
               end
            end else begin
               w_div_nxt = r_div + 8'd1;
            end
         end
`ifdef DAC_SPI_LDAC_EN
         ST_LDAC: begin
            if (r_div == DIV_MAX) begin
               w_div_nxt    = 8'd0;
               w_ldac_n_nxt = 1'b1;
               w_state_nxt  = ST_GAP;
            end else begin
               w_div_nxt = r_div + 8'd1;
            end
         end
`endif
         ST_GAP: begin
            w_div_nxt   = 8'd0;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_div_nxt   = 8'd0;
            w_bit_nxt   = 4'd0;
            w_shift_nxt = 16'd0;
            w_sclk_nxt  = 1'b0;
            w_cs_n_nxt  = 1'b1;
`ifdef DAC_SPI_LDAC_EN
            w_ldac_n_nxt = 1'b1;
`endif
         end
      endcase
   end

   // Registered datapath and SPI pins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div   <= 8'd0;
         r_bit   <= 4'd0;
         r_shift <= 16'd0;
         r_sclk  <= 1'b0;
         r_cs_n  <= 1'b1;
         r_busy  <= 1'b0;
`ifdef DAC_SPI_LDAC_EN
         r_ldac_n <= 1'b1;
`endif
      end else begin
         r_div   <= w_div_nxt;
         r_bit   <= w_bit_nxt;
         r_shift <= w_shift_nxt;
         r_sclk  <= w_sclk_nxt;
         r_cs_n  <= w_cs_n_nxt;
         r_busy  <= (w_state_nxt != ST_IDLE);
`ifdef DAC_SPI_LDAC_EN
         r_ldac_n <= w_ldac_n_nxt;
`endif
      end
   end

   // Dropped-tick pulse and saturating drop counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_overrun     <= 1'b0;
         r_overrun_cnt <= 8'd0;
      end else begin
         r_overrun <= w_drop;
         if (w_drop && (r_overrun_cnt != 8'hFF)) begin
            r_overrun_cnt <= r_overrun_cnt + 8'd1;
         end else begin
            r_overrun_cnt <= r_overrun_cnt;
         end
      end
   end

   assign sclk        = r_sclk;
   assign cs_n        = r_cs_n;
   assign mosi        = r_shift[15];
   assign busy        = r_busy;
   assign overrun     = r_overrun;
   assign overrun_cnt = r_overrun_cnt;
`ifdef DAC_SPI_LDAC_EN
   assign ldac_n = r_ldac_n;
`else
   assign ldac_n = 1'b0;
`endif

endmodule

// File: tb/tb_dac_spi_streamer.sv
// Directed bench: frame-content vector table plus sequences for late sample change, mid-frame reset,
// enable drop, frame rate and overrun saturation. Expectations follow DAC_SPI_LDAC_EN if defined.
module tb_dac_spi_streamer;

   logic       clk = 1'b0;
   logic       a_rst, a_en, b_rst, b_en;
   logic [9:0] a_sample, b_sample;
   logic       a_sclk, a_cs_n, a_mosi, a_ldac_n, a_busy, a_ovr;
   logic [7:0] a_cnt;
   logic       b_sclk, b_cs_n, b_mosi, b_ldac_n, b_busy, b_ovr;
   logic [7:0] b_cnt;

   int n_pass = 0;
   int n_total = 0;

`ifdef DAC_SPI_LDAC_EN
   localparam int EXP_IDLE_LAT = 68;
`else
   localparam int EXP_IDLE_LAT = 66;
`endif

   always #5 clk = ~clk;

   dac_spi_streamer #(.CLK_DIV(2), .SAMPLE_DIV(100), .CTRL_BITS(4'b0011)) u_dut_a (
      .clk(clk), .rst(a_rst), .enable(a_en), .sample_in(a_sample),
      .sclk(a_sclk), .cs_n(a_cs_n), .mosi(a_mosi), .ldac_n(a_ldac_n),
      .busy(a_busy), .overrun(a_ovr), .overrun_cnt(a_cnt));

   dac_spi_streamer #(.CLK_DIV(2), .SAMPLE_DIV(40), .CTRL_BITS(4'b0011)) u_dut_b (
      .clk(clk), .rst(b_rst), .enable(b_en), .sample_in(b_sample),
      .sclk(b_sclk), .cs_n(b_cs_n), .mosi(b_mosi), .ldac_n(b_ldac_n),
      .busy(b_busy), .overrun(b_ovr), .overrun_cnt(b_cnt));

   typedef struct {
      logic [9:0]  sample;
      logic [15:0] frame;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic pulse_reset_a();
      a_rst = 1'b1;
      a_en  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      a_rst = 1'b0;
      @(negedge clk);
   endtask

   // Waits for the frame start, then records the SPI pins each cycle until busy falls.
   task automatic run_frame(input logic [9:0] samp, input bit change_late, input logic [9:0] late_samp,
                            input bit drop_en, output logic [15:0] bits, output int nrise,
                            output int cs_low, output int ldac_low, output int ldac_high,
                            output int idle_lat, output int tick_lat, output int mosi_viol);
      logic prev_sclk, prev_mosi;
      bits = 16'd0; nrise = 0; cs_low = 0; ldac_low = 0; ldac_high = 0;
      idle_lat = 0; tick_lat = -1; mosi_viol = 0;
      prev_sclk = 1'b0; prev_mosi = 1'b0;
      a_sample = samp;
      a_en     = 1'b1;
      for (int i = 1; i <= 300; i++) begin
         @(negedge clk);
         if (a_cs_n == 1'b0) begin
            tick_lat = i;
            break;
         end
      end
      if (tick_lat < 0) return;
      if (change_late) a_sample = late_samp;
      for (int k = 0; k < 200; k++) begin
         if (k > 0) begin
            if (!prev_sclk && a_sclk) begin
               bits  = {bits[14:0], a_mosi};
               nrise++;
            end
            if ((a_mosi != prev_mosi) && !(prev_sclk && !a_sclk)) mosi_viol++;
         end
         if (!a_cs_n) cs_low++;
         if (!a_ldac_n) ldac_low++;
         if (a_ldac_n) ldac_high++;
         if (drop_en && k == 10) a_en = 1'b0;
         if (!a_busy) begin
            idle_lat = k + 1;
            break;
         end
         prev_sclk = a_sclk;
         prev_mosi = a_mosi;
         @(negedge clk);
      end
   endtask

   task automatic check_frame(input string tag, input logic [9:0] samp, input bit change_late,
                              input logic [9:0] late_samp, input bit drop_en, input logic [15:0] exp_frame);
      logic [15:0] bits;
      int nrise, cs_low, ldac_low, ldac_high, idle_lat, tick_lat, viol;
      run_frame(samp, change_late, late_samp, drop_en, bits, nrise, cs_low, ldac_low, ldac_high,
                idle_lat, tick_lat, viol);
      chk({tag, " tick_latency"}, tick_lat, 100);
      chk({tag, " frame_bits"}, int'(bits), int'(exp_frame));
      chk({tag, " sclk_rises"}, nrise, 16);
      chk({tag, " cs_n_low_cycles"}, cs_low, 64);
      chk({tag, " mosi_change_off_fall"}, viol, 0);
      chk({tag, " tick_to_idle"}, idle_lat, EXP_IDLE_LAT);
`ifdef DAC_SPI_LDAC_EN
      chk({tag, " ldac_n_low_cycles"}, ldac_low, 2);
`else
      chk({tag, " ldac_n_high_cycles"}, ldac_high, 0);
`endif
      chk({tag, " idle_outputs"}, int'({a_sclk, a_cs_n, a_mosi}), int'(3'b010));
   endtask

   initial begin
      int frames, pulses, wide, mis, ldac_pulse, cs_seen;
      logic prev_cs, prev_ovr;

      vecs[0] = '{sample: 10'h2AA, frame: 16'h3AA8};
      vecs[1] = '{sample: 10'h000, frame: 16'h3000};
      vecs[2] = '{sample: 10'h3FF, frame: 16'h3FFC};
      vecs[3] = '{sample: 10'h155, frame: 16'h3554};
      vecs[4] = '{sample: 10'h001, frame: 16'h3004};
      vecs[5] = '{sample: 10'h200, frame: 16'h3800};

      a_rst = 1'b1; b_rst = 1'b1; a_en = 1'b0; b_en = 1'b0;
      a_sample = 10'h000; b_sample = 10'h100;
      repeat (3) @(negedge clk);

      chk("reset_sclk", int'(a_sclk), 0);
      chk("reset_cs_n", int'(a_cs_n), 1);
      chk("reset_mosi", int'(a_mosi), 0);
      chk("reset_busy", int'(a_busy), 0);
      chk("reset_overrun", int'(a_ovr), 0);
      chk("reset_overrun_cnt", int'(b_cnt), 0);
`ifdef DAC_SPI_LDAC_EN
      chk("reset_ldac_n", int'(a_ldac_n), 1);
`else
      chk("reset_ldac_n_tied", int'(a_ldac_n), 0);
`endif
      a_rst = 1'b0;
      @(negedge clk);

      for (int v = 0; v < 6; v++) begin
         check_frame($sformatf("vec%0d", v), vecs[v].sample, 1'b0, 10'h000, 1'b0, vecs[v].frame);
         pulse_reset_a();
      end

      // Sample changes the cycle after the tick; frame must still carry the latched zero.
      check_frame("late_sample", 10'h000, 1'b1, 10'h3FF, 1'b0, 16'h3000);
      pulse_reset_a();

      // Reset at the 20th SHIFT cycle aborts immediately and asynchronously.
      a_sample = 10'h155;
      a_en = 1'b1;
      cs_seen = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (!a_cs_n) begin
            cs_seen = 1;
            break;
         end
      end
      chk("midreset_frame_started", cs_seen, 1);
      repeat (19) @(negedge clk);
      a_rst = 1'b1;
      a_en  = 1'b0;
      #1;
      chk("midreset_cs_n", int'(a_cs_n), 1);
      chk("midreset_sclk", int'(a_sclk), 0);
      chk("midreset_busy", int'(a_busy), 0);
      ldac_pulse = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
`ifdef DAC_SPI_LDAC_EN
         if (!a_ldac_n) ldac_pulse++;
`else
         if (a_ldac_n) ldac_pulse++;
`endif
      end
      chk("midreset_no_ldac_pulse", ldac_pulse, 0);
      a_rst = 1'b0;
      @(negedge clk);
      check_frame("after_reset", 10'h2AA, 1'b0, 10'h000, 1'b0, 16'h3AA8);
      pulse_reset_a();

      // Enable dropped mid-frame: frame completes, no further frames.
      check_frame("enable_drop", 10'h3FF, 1'b0, 10'h000, 1'b1, 16'h3FFC);
      cs_seen = 0;
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         if (!a_cs_n) cs_seen++;
      end
      chk("enable_drop_no_new_frame", cs_seen, 0);
      pulse_reset_a();

      // 1000 cycles of enable at SAMPLE_DIV=100 gives ten frames, no drops.
      frames = 0; pulses = 0; prev_cs = 1'b1;
      a_sample = 10'h0F0;
      a_en = 1'b1;
      for (int i = 0; i < 1200; i++) begin
         @(negedge clk);
         if (i == 999) a_en = 1'b0;
         if (prev_cs && !a_cs_n) frames++;
         if (a_ovr) pulses++;
         prev_cs = a_cs_n;
      end
      chk("rate_frames", frames, 10);
      chk("rate_overrun_pulses", pulses, 0);
      chk("rate_overrun_cnt", int'(a_cnt), 0);

      // SAMPLE_DIV=40 drops every other tick; counter saturates at 255.
      b_rst = 1'b0;
      @(negedge clk);
      frames = 0; pulses = 0; wide = 0; mis = 0;
      prev_cs = 1'b1; prev_ovr = 1'b0;
      b_en = 1'b1;
      for (int i = 1; i <= 24080; i++) begin
         @(negedge clk);
         if (i == 23980) b_en = 1'b0;
         if (prev_cs && !b_cs_n) frames++;
         if (b_ovr) begin
            pulses++;
            if (prev_ovr) wide++;
            if (int'(b_cnt) != ((pulses > 255) ? 255 : pulses)) mis++;
         end
         prev_cs  = b_cs_n;
         prev_ovr = b_ovr;
      end
      chk("ovr_frames", frames, 300);
      chk("ovr_pulses", pulses, 299);
      chk("ovr_pulse_width", wide, 0);
      chk("ovr_cnt_tracking", mis, 0);
      chk("ovr_cnt_saturated", int'(b_cnt), 255);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
